seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a frame-synchronous shadow register.
// Define SEG7_SCAN_LZB_EN to blank leading zero digits (digits 3..1).
module seg7_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  output logic        ready,
  output logic [6:0]  a_to_g,
  output logic [3:0]  an,
  output logic        dp,
  output logic        err
);

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d, shadow_q, shadow_d;
  logic [3:0]    disp_dp_q, disp_dp_d, shadow_dp_q, shadow_dp_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          err_q, err_d;

  logic          tick, frame, accept, active, dp_bit;
  logic [3:0]    digit;

  assign tick   = (presc_q == PRESC_LAST);
  assign frame  = tick && (idx_q == 2'd3);
  assign accept = load && !pending_q;

  always_comb begin
    digit  = disp_q[3:0];
    dp_bit = disp_dp_q[0];
    case (idx_q)
      2'd1:    begin digit = disp_q[7:4];   dp_bit = disp_dp_q[1]; end
      2'd2:    begin digit = disp_q[11:8];  dp_bit = disp_dp_q[2]; end
      2'd3:    begin digit = disp_q[15:12]; dp_bit = disp_dp_q[3]; end
      default: ;
    endcase
  end

  always_comb begin
    active = (presc_q >= BLANK_LIM);
`ifdef SEG7_SCAN_LZB_EN
    case (idx_q)
      2'd3:    if (disp_q[15:12] == '0) active = 1'b0;
      2'd2:    if (disp_q[15:8]  == '0) active = 1'b0;
      2'd1:    if (disp_q[15:4]  == '0) active = 1'b0;
      default: ;
    endcase
`endif
  end

  always_comb begin
    case (digit)
      4'd0:    seg_d = 7'b0000001;
      4'd1:    seg_d = 7'b1001111;
      4'd2:    seg_d = 7'b0010010;
      4'd3:    seg_d = 7'b0000110;
      4'd4:    seg_d = 7'b1001100;
      4'd5:    seg_d = 7'b0100100;
      4'd6:    seg_d = 7'b0100000;
      4'd7:    seg_d = 7'b0001111;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0000100;
      default: seg_d = 7'b1111111;
    endcase
    an_d  = active ? ~(4'b0001 << idx_q) : 4'b1111;
    dp_d  = active ? ~dp_bit : 1'b1;
    err_d = err_q | (active && (digit > 4'd9));
  end

  // Display swap uses the pending flag from before this edge, so a load
  // accepted on a frame-boundary tick waits for the following boundary.
  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;
    if (frame && pending_q) begin
      disp_d    = shadow_q;
      disp_dp_d = shadow_dp_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d    = din;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc_q     <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pending_q   <= 1'b0;
      an_q        <= '1;
      seg_q       <= '1;
      dp_q        <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      err_q       <= err_d;
    end
  end

  assign ready  = !pending_q;
  assign a_to_g = seg_q;
  assign an     = an_q;
  assign dp     = dp_q;
  assign err    = err_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: cycle-count based reference model, randomized and directed scenarios.
module tb_seg7_scan_ctrl;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BLK   = 1;
  localparam int unsigned FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        clr, load;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        ready, dp, err;
  logic [6:0]  a_to_g;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .clk(clk), .clr(clr), .load(load), .din(din), .dp_in(dp_in),
    .ready(ready), .a_to_g(a_to_g), .an(an), .dp(dp), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset gives slot/digit by plain division.
  int unsigned m_n;
  logic [15:0] m_disp, m_sh;
  logic [3:0]  m_ddp, m_shdp;
  bit          m_pend, m_err;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  function automatic logic [6:0] seg_of(int unsigned d);
    logic [6:0] tbl [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
    return (d < 10) ? tbl[d] : 7'h7F;
  endfunction

  function automatic bit lead_zero(logic [15:0] v, int unsigned k);
`ifdef SEG7_SCAN_LZB_EN
    return (k > 0) && ((v >> (4 * k)) == 16'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [13:0] expected();
    return {e_an, e_seg, e_dp, !m_pend, m_err};
  endfunction

  always @(posedge clk or posedge clr) begin : model
    int unsigned k, p, d;
    bit act, fb, acc;
    if (clr) begin
      m_n = 0; m_disp = '0; m_sh = '0; m_ddp = '0; m_shdp = '0;
      m_pend = 0; m_err = 0; e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      k = (m_n / DIV) % 4;
      p = m_n % DIV;
      d = (m_disp >> (4 * k)) & 16'hF;
      act = (p >= BLK) && !lead_zero(m_disp, k);
      e_an  = act ? ~(4'b0001 << k) : 4'hF;
      e_seg = seg_of(d);
      e_dp  = act ? ~m_ddp[k] : 1'b1;
      if (act && d > 9) m_err = 1;
      fb  = (m_n % FRAME) == FRAME - 1;
      acc = load && !m_pend;
      if (fb && m_pend) begin m_disp = m_sh; m_ddp = m_shdp; m_pend = 0; end
      if (acc) begin m_sh = din; m_shdp = dp_in; m_pend = 1; end
      m_n++;
    end
  end

  task automatic test_reset();
    clr = 1; load = 0; din = '0; dp_in = '0;
    @(negedge clk);
    checks++;
    if ({an, a_to_g, dp, ready, err} !== 14'b1111_1111111_1_1_0) begin
      errors++; $display("FAIL reset_init got=%b want=%b", {an, a_to_g, dp, ready, err}, 14'b1111_1111111_1_1_0);
    end
    clr = 0;
    for (int i = 0; i < 10; i++) begin
      load = (i == 2); din = 16'h4321; dp_in = 4'hF;
      @(negedge clk);
      checks++;
      if ({an, a_to_g, dp, ready, err} !== expected()) begin
        errors++; $display("FAIL reset_run cyc=%0d got=%b want=%b", i, {an, a_to_g, dp, ready, err}, expected());
      end
    end
    load = 0;
    #2 clr = 1;
    #1;
    checks++;
    if ({an, a_to_g, dp, ready, err} !== 14'b1111_1111111_1_1_0) begin
      errors++; $display("FAIL reset_async got=%b want=%b", {an, a_to_g, dp, ready, err}, 14'b1111_1111111_1_1_0);
    end
    @(negedge clk);
    clr = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, a_to_g, dp, ready, err} !== expected()) begin
        errors++; $display("FAIL reset_discard cyc=%0d got=%b want=%b", i, {an, a_to_g, dp, ready, err}, expected());
      end
    end
  endtask

  task automatic test_scan();
    bit seen4 = 0;
    clr = 1;
    @(negedge clk);
    clr = 0; load = 1; din = 16'h1234; dp_in = 4'h0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      load = 0;
      if (an == 4'b1110 && a_to_g == 7'b1001100) seen4 = 1;
      checks++;
      if ({an, a_to_g, dp, ready, err} !== expected()) begin
        errors++; $display("FAIL scan cyc=%0d got=%b want=%b", i, {an, a_to_g, dp, ready, err}, expected());
      end
    end
    checks++;
    if (seen4 !== 1'b1) begin
      errors++; $display("FAIL scan_digit4 seen=%0d want=1", seen4);
    end
  endtask

  task automatic test_handshake();
    while (m_n % FRAME != 5) @(negedge clk);
    load = 1; din = 16'h5678; dp_in = 4'h0;
    @(negedge clk);
    load = 0;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL hs_ready_low got=%b want=0", ready);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      load = (i == 2); din = 16'h9999;
      @(negedge clk);
      checks++;
      if ({an, a_to_g, dp, ready, err} !== expected()) begin
        errors++; $display("FAIL handshake cyc=%0d got=%b want=%b", i, {an, a_to_g, dp, ready, err}, expected());
      end
    end
    load = 0;
    checks++;
    if (m_disp !== 16'h5678 || ready !== 1'b1) begin
      errors++; $display("FAIL hs_final ready=%b want=1 model_disp=%h want=5678", ready, m_disp);
    end
  endtask

  task automatic test_invalid();
    logic [15:0] vals [2] = '{16'h00A0, 16'h0000};
    for (int v = 0; v < 2; v++) begin
      while (!ready) @(negedge clk);
      load = 1; din = vals[v]; dp_in = 4'h0;
      for (int i = 0; i < 2 * FRAME + 2; i++) begin
        @(negedge clk);
        load = 0;
        checks++;
        if ({an, a_to_g, dp, ready, err} !== expected()) begin
          errors++; $display("FAIL invalid v=%h cyc=%0d got=%b want=%b", vals[v], i, {an, a_to_g, dp, ready, err}, expected());
        end
      end
      checks++;
      if (err !== 1'b1) begin
        errors++; $display("FAIL invalid_err_sticky v=%h got=%b want=1", vals[v], err);
      end
    end
    clr = 1;
    @(negedge clk);
    clr = 0;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL invalid_err_clear got=%b want=0", err);
    end
  endtask

  task automatic test_boundary();
    int unsigned guard = 0;
    int unsigned bad_dp = 0;
    while (!(ready && (m_n % FRAME) == FRAME - 1) && guard < 100) begin
      @(negedge clk); guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++; $display("FAIL boundary_wait cycles=%0d limit=100", guard);
    end
    load = 1; din = 16'h8765; dp_in = 4'b0100;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      load = 0;
      if (dp == 1'b0 && an != 4'b1011) bad_dp++;
      checks++;
      if ({an, a_to_g, dp, ready, err} !== expected()) begin
        errors++; $display("FAIL boundary cyc=%0d got=%b want=%b", i, {an, a_to_g, dp, ready, err}, expected());
      end
    end
    checks++;
    if (bad_dp != 0) begin
      errors++; $display("FAIL boundary_dp stray_dp_cycles=%0d want=0", bad_dp);
    end
  endtask

  task automatic test_lzb();
    clr = 1;
    @(negedge clk);
    clr = 0; load = 1; din = 16'h0070; dp_in = 4'h0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      load = 0;
      checks++;
      if ({an, a_to_g, dp, ready, err} !== expected()) begin
        errors++; $display("FAIL lzb cyc=%0d got=%b want=%b", i, {an, a_to_g, dp, ready, err}, expected());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      clr   = ($urandom_range(0, 149) == 0);
      load  = ($urandom_range(0, 3) == 0);
      din   = 16'($urandom);
      if ($urandom_range(0, 3) != 0) din = din & 16'h7777;
      dp_in = 4'($urandom);
      @(negedge clk);
      checks++;
      if ({an, a_to_g, dp, ready, err} !== expected()) begin
        errors++; $display("FAIL random cyc=%0d got=%b want=%b", i, {an, a_to_g, dp, ready, err}, expected());
      end
    end
    clr = 0; load = 0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_handshake();
    test_invalid();
    test_boundary();
    test_lzb();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
